// File: rtl/lifn_pkg.sv
// Shared types and arithmetic for the time-multiplexed LIF neuron scheduler.
// Scheduler FSM encoding, datapath widths and the saturating membrane update.
package lifn_pkg;

    localparam int STATE_W = 8;
    localparam int CUR_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } fsm_state_t;

    // Leak (or reset on spike), add the input current, clamp at full scale instead of wrapping.
    function automatic logic [STATE_W-1:0] sat_update(
        input logic [STATE_W-1:0] s,
        input logic [CUR_W-1:0]   c,
        input logic               spike,
        input int unsigned        leak_shift
    );
        logic [STATE_W-1:0] base;
        logic [STATE_W:0]   sum;
        base = spike ? '0 : s - (s >> leak_shift);
        sum  = {1'b0, base} + {1'b0, c};
        return sum[STATE_W] ? '1 : sum[STATE_W-1:0];
    endfunction

endpackage

// File: rtl/lifn_update.sv
// Combinational LIF neuron update: old state, current and threshold in,
// next state and spike flag out.
module lifn_update
    import lifn_pkg::*;
#(
    parameter int LEAK_SHIFT = 1
) (
    input  logic [STATE_W-1:0] s,
    input  logic [CUR_W-1:0]   c,
    input  logic [STATE_W-1:0] thr,
    output logic [STATE_W-1:0] next_s,
    output logic               spike
);

    always_comb begin
        spike  = (s >= thr);
        next_s = sat_update(s, c, spike, LEAK_SHIFT);
    end

endmodule

// File: rtl/lifn_scheduler.sv
// Sweeps one shared LIF update datapath over NUM_NEURONS virtual neurons, two cycles each.
// Optional per-neuron refractory counters are enabled by defining LIFN_REFRACTORY_EN.
module lifn_scheduler
    import lifn_pkg::*;
#(
    parameter int NUM_NEURONS  = 4,
    parameter int ADDR_W       = 2,
    parameter int LEAK_SHIFT   = 1,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_start,
    input  logic [STATE_W-1:0]     threshold,
    input  logic                   cur_we,
    input  logic [ADDR_W-1:0]      cur_addr,
    input  logic [CUR_W-1:0]       cur_data,
    input  logic [ADDR_W-1:0]      mon_addr,
    output logic [STATE_W-1:0]     mon_state,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spike_vec
);

    fsm_state_t               st;
    logic [ADDR_W-1:0]        idx;
    logic [STATE_W-1:0]       thr_q;
    logic [STATE_W-1:0]       state_mem [NUM_NEURONS];
    logic [CUR_W-1:0]         cur_mem   [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   pending;
    logic [NUM_NEURONS-1:0]   pending_nxt;
    logic [STATE_W-1:0]       s_p0;
    logic [CUR_W-1:0]         c_p0;
    logic [STATE_W-1:0]       upd_next;
    logic                     upd_spike;
    logic [STATE_W-1:0]       commit_next;
    logic                     commit_spike;

`ifdef LIFN_REFRACTORY_EN
    localparam int RC_W = ($clog2(REFRAC_STEPS + 1) < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
    logic [RC_W-1:0]          rcnt [NUM_NEURONS];
    logic                     refrac_p0;
`endif

    lifn_update #(
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_update (
        .s      (s_p0),
        .c      (c_p0),
        .thr    (thr_q),
        .next_s (upd_next),
        .spike  (upd_spike)
    );

    // A refractory neuron is held at zero and cannot report a spike.
    always_comb begin
`ifdef LIFN_REFRACTORY_EN
        commit_next  = refrac_p0 ? '0 : upd_next;
        commit_spike = refrac_p0 ? 1'b0 : upd_spike;
`else
        commit_next  = upd_next;
        commit_spike = upd_spike;
`endif
        pending_nxt      = pending;
        pending_nxt[idx] = commit_spike;
    end

    assign mon_state = state_mem[mon_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            idx       <= '0;
            thr_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spike_vec <= '0;
            pending   <= '0;
            s_p0      <= '0;
            c_p0      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                state_mem[i] <= '0;
                cur_mem[i]   <= '0;
`ifdef LIFN_REFRACTORY_EN
                rcnt[i]      <= '0;
`endif
            end
`ifdef LIFN_REFRACTORY_EN
            refrac_p0 <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (cur_we)
                cur_mem[cur_addr] <= cur_data;
            case (st)
                IDLE: begin
                    if (step_start) begin
                        st      <= FETCH;
                        idx     <= '0;
                        thr_q   <= threshold;
                        pending <= '0;
                        busy    <= 1'b1;
                    end
                end
                // FETCH/COMMIT boundary: old state and current captured for the update.
                FETCH: begin
                    s_p0 <= state_mem[idx];
                    c_p0 <= cur_mem[idx];
`ifdef LIFN_REFRACTORY_EN
                    refrac_p0 <= (rcnt[idx] != '0);
`endif
                    st   <= COMMIT;
                end
                COMMIT: begin
                    state_mem[idx] <= commit_next;
                    pending        <= pending_nxt;
`ifdef LIFN_REFRACTORY_EN
                    if (refrac_p0)
                        rcnt[idx] <= rcnt[idx] - 1'b1;
                    else if (upd_spike)
                        rcnt[idx] <= RC_W'(REFRAC_STEPS);
`endif
                    if (idx == ADDR_W'(NUM_NEURONS - 1)) begin
                        st        <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        spike_vec <= pending_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                        st  <= FETCH;
                    end
                end
                DONE: begin
                    st <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifn_scheduler.sv
// Self-checking bench for lifn_scheduler: table of sweeps with a scoreboard,
// plus directed sequences for timing, same-cycle current write and mid-sweep reset.
module tb_lifn_scheduler;

    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_start;
    logic [7:0]    threshold;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [7:0]    cur_data;
    logic [AW-1:0] mon_addr;
    logic [7:0]    mon_state;
    logic          busy;
    logic          done;
    logic [N-1:0]  spike_vec;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic            do_rst;
        logic [7:0]      thr;
        logic [3:0][7:0] cur;
        logic [3:0][7:0] exp_st;
        logic [3:0]      exp_spk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    lifn_scheduler #(
        .NUM_NEURONS (N),
        .ADDR_W      (AW),
        .LEAK_SHIFT  (1),
        .REFRAC_STEPS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_start(step_start),
        .threshold (threshold),
        .cur_we    (cur_we),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .mon_addr  (mon_addr),
        .mon_state (mon_state),
        .busy      (busy),
        .done      (done),
        .spike_vec (spike_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [7:0] thr,
                                input logic [7:0] c0, c1, c2, c3,
                                input logic [7:0] s0, s1, s2, s3,
                                input logic [3:0] spk);
        vec_t v;
        v.do_rst  = r;
        v.thr     = thr;
        v.cur     = {c3, c2, c1, c0};
        v.exp_st  = {s3, s2, s1, s0};
        v.exp_spk = spk;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        step_start = 1'b0;
        cur_we     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_cur(input logic [AW-1:0] a, input logic [7:0] d);
        cur_we   = 1'b1;
        cur_addr = a;
        cur_data = d;
        @(negedge clk);
        cur_we = 1'b0;
    endtask

    task automatic wait_done(input string name, output logic ok);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = done;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no done pulse within %0d cycles", name, n);
        end
    endtask

    task automatic check_states(input string name, input logic [3:0][7:0] exp_st);
        for (int a = 0; a < N; a++) begin
            mon_addr = AW'(a);
            #1;
            chk($sformatf("%s state[%0d]", name, a), mon_state, exp_st[a]);
        end
    endtask

    // Scoreboard: expectation queued when the step is issued, retired on done.
    task automatic run_sweep(input string name, input vec_t v);
        logic ok;
        vec_t e;
        sb.push_back(v);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        wait_done(name, ok);
        e = sb.pop_front();
        if (ok) begin
            chk({name, " spike_vec"}, spike_vec, e.exp_spk);
            check_states(name, e.exp_st);
            @(negedge clk);
        end
    endtask

    initial begin
        logic ok;
        int   ndone;
        vec_t v;

        rst = 1'b1; step_start = 1'b0; threshold = 8'd0; cur_we = 1'b0;
        cur_addr = '0; cur_data = '0; mon_addr = '0;

        do_reset();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset spike_vec", spike_vec, 0);
        check_states("reset", '0);

        // Leak/integrate/spike sequence on neuron 0.
        add(1, 100,  60, 0, 0, 0,   60, 0, 0, 0, 4'b0000);
        add(0, 100,  60, 0, 0, 0,   90, 0, 0, 0, 4'b0000);
        add(0, 100,  60, 0, 0, 0,  105, 0, 0, 0, 4'b0000);
        add(0, 100,  60, 0, 0, 0,   60, 0, 0, 0, 4'b0001);
        // Full-scale current, threshold at full scale.
        add(1, 255,  0, 255, 0, 0,  0, 255, 0, 0, 4'b0000);
        add(0, 255,  0, 255, 0, 0,  0, 255, 0, 0, 4'b0010);
        // Sum exceeding 255 clamps rather than wrapping.
        add(1, 255,  0, 0, 200, 0,  0, 0, 200, 0, 4'b0000);
        add(0, 255,  0, 0, 200, 0,  0, 0, 255, 0, 4'b0000);
        add(0, 255,  0, 0, 200, 0,  0, 0, 200, 0, 4'b0100);
`ifdef LIFN_REFRACTORY_EN
        add(1, 100,  120, 0, 0, 0,  120, 0, 0, 0, 4'b0000);
        add(0, 100,  120, 0, 0, 0,  120, 0, 0, 0, 4'b0001);
        add(0, 100,  120, 0, 0, 0,    0, 0, 0, 0, 4'b0000);
        add(0, 100,  120, 0, 0, 0,    0, 0, 0, 0, 4'b0000);
        add(0, 100,  120, 0, 0, 0,  120, 0, 0, 0, 4'b0000);
`else
        // Threshold zero: every neuron fires every sweep.
        add(1, 0,    10, 20, 30, 40,  10, 20, 30, 40, 4'b1111);
        add(0, 0,    10, 20, 30, 40,  10, 20, 30, 40, 4'b1111);
        // Mixed neurons at threshold 100.
        add(1, 100,  50, 120, 0, 255,  50, 120, 0, 255, 4'b0000);
        add(0, 100,  50, 120, 0, 255,  75, 120, 0, 255, 4'b1010);
        add(0, 100,  50, 120, 0, 255,  88, 120, 0, 255, 4'b1010);
`endif

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            if (v.do_rst) do_reset();
            for (int a = 0; a < N; a++) write_cur(AW'(a), v.cur[a]);
            threshold = v.thr;
            run_sweep($sformatf("row%0d", r), v);
        end

        // Sweep timing and step_start ignored while busy.
        do_reset();
        threshold  = 8'd100;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("timing busy t+%0d", i), busy, (i <= 8) ? 1 : 0);
            chk($sformatf("timing done t+%0d", i), done, (i == 9) ? 1 : 0);
            if (done) ndone++;
            step_start = (i == 3);
            @(negedge clk);
        end
        step_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("timing done count", ndone, 1);

        // Current write in the same cycle neuron 2 is fetched.
        do_reset();
        write_cur(2'd2, 8'd10);
        threshold  = 8'd255;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        repeat (4) @(negedge clk);
        cur_we = 1'b1; cur_addr = 2'd2; cur_data = 8'd50;
        @(negedge clk);
        cur_we = 1'b0;
        wait_done("samecycle", ok);
        if (ok) begin
            check_states("samecycle old", {8'd0, 8'd10, 8'd0, 8'd0});
            @(negedge clk);
        end
        v = '{do_rst: 1'b0, thr: 8'd255, cur: '0,
              exp_st: {8'd0, 8'd55, 8'd0, 8'd0}, exp_spk: 4'b0000};
        run_sweep("samecycle new", v);

        // Reset in the middle of a sweep.
        do_reset();
        write_cur(2'd0, 8'd120);
        threshold = 8'd100;
        v = '{do_rst: 1'b0, thr: 8'd100, cur: '0,
              exp_st: {8'd0, 8'd0, 8'd0, 8'd120}, exp_spk: 4'b0000};
        run_sweep("prerst1", v);
        v.exp_spk = 4'b0001;
        run_sweep("prerst2", v);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst spike_vec", spike_vec, 0);
        check_states("midrst", '0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst no done", ndone, 0);
        v = '{do_rst: 1'b0, thr: 8'd100, cur: '0, exp_st: '0, exp_spk: 4'b0000};
        run_sweep("postrst", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
